// File: rtl/llc_cmd_dispatch_pkg.sv
// Shared types and constants for the LLC command dispatch front end:
// address split, trace opcodes and the decoded cache request kinds.
package llc_cmd_dispatch_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int OFFSET_BITS   = 6;
    localparam int INDEX_BITS    = 14;
    localparam int TAG_BITS      = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int OP_WIDTH      = 4;

    typedef enum logic [2:0] {
        PR_READ   = 3'd0,
        PR_WRITE  = 3'd1,
        PR_IFETCH = 3'd2,
        SN_READ   = 3'd3,
        SN_WRITE  = 3'd4,
        SN_RWIM   = 3'd5,
        SN_INVAL  = 3'd6
    } req_kind_t;

    localparam logic [OP_WIDTH-1:0] OP_PR_READ   = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_PR_WRITE  = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_PR_IFETCH = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_SN_READ   = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_SN_WRITE  = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_SN_RWIM   = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_SN_INVAL  = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_CLEAR     = 4'd8;
    localparam logic [OP_WIDTH-1:0] OP_PRINT     = 4'd9;

    function automatic logic is_cache_op(input logic [OP_WIDTH-1:0] op);
        return op <= OP_SN_INVAL;
    endfunction

    function automatic req_kind_t op_to_kind(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_PR_WRITE:  return PR_WRITE;
            OP_PR_IFETCH: return PR_IFETCH;
            OP_SN_READ:   return SN_READ;
            OP_SN_WRITE:  return SN_WRITE;
            OP_SN_RWIM:   return SN_RWIM;
            OP_SN_INVAL:  return SN_INVAL;
            default:      return PR_READ;
        endcase
    endfunction

    function automatic logic is_proc_kind(input req_kind_t kind);
        return (kind == PR_READ) || (kind == PR_WRITE) || (kind == PR_IFETCH);
    endfunction

endpackage

// File: rtl/llc_cmd_dispatch_if.sv
// Trace command, cache request and cache response signals between the
// dispatch stage (slave) and its surroundings (master).
interface llc_cmd_dispatch_if;
    import llc_cmd_dispatch_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [OP_WIDTH-1:0]      cmd_op;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic                     req_valid;
    logic                     req_ready;
    req_kind_t                req_kind;
    logic [TAG_BITS-1:0]      req_tag;
    logic [INDEX_BITS-1:0]    req_index;
    logic                     rsp_valid;
    logic                     rsp_hit;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, req_ready, rsp_valid, rsp_hit,
        input  cmd_ready, req_valid, req_kind, req_tag, req_index
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, req_ready, rsp_valid, rsp_hit,
        output cmd_ready, req_valid, req_kind, req_tag, req_index
    );

endinterface

// File: rtl/llc_cmd_fifo.sv
// Synchronous FIFO for trace commands; a push while full is refused even
// when a pop happens in the same cycle.
module llc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/llc_cmd_dispatch.sv
// Dispatch stage in front of the LLC lookup: decodes buffered trace
// commands, issues one cache request at a time and keeps statistics.
//
//   state    | meaning
//   IDLE     | decode FIFO head; illegal opcodes are dropped here
//   ISSUE    | req_valid high, waiting for req_ready
//   WAIT_RSP | request accepted, waiting for rsp_valid
//   CLEAR    | one-cycle clear_pulse, counters zeroed
//   PRINT    | one-cycle print_pulse
module llc_cmd_dispatch
    import llc_cmd_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    llc_cmd_dispatch_if.slave    bus,
    output logic                 clear_pulse,
    output logic                 print_pulse,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cnt_reads,
    output logic [CNT_WIDTH-1:0] cnt_writes,
    output logic [CNT_WIDTH-1:0] cnt_hits,
    output logic [CNT_WIDTH-1:0] cnt_misses,
    output logic [CNT_WIDTH-1:0] cnt_err
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_RSP = 3'd2;
    localparam logic [2:0] S_CLEAR    = 3'd3;
    localparam logic [2:0] S_PRINT    = 3'd4;
    localparam int         ENTRY_W    = OP_WIDTH + ADDRESS_WIDTH;

    logic [2:0]               state;
    logic [ENTRY_W-1:0]       head;
    logic [OP_WIDTH-1:0]      head_op;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    req_kind_t                req_kind_r;
    logic [TAG_BITS-1:0]      req_tag_r;
    logic [INDEX_BITS-1:0]    req_index_r;
    logic                     head_illegal;
    logic                     grant;
    logic                     rsp_done;
    logic                     inc_read, inc_write, inc_hit, inc_miss, inc_err;
    logic                     unused_offset;

    llc_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.cmd_valid),
        .push_data ({bus.cmd_op, bus.cmd_addr}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_op       = head[ENTRY_W-1 -: OP_WIDTH];
    assign head_addr     = head[ADDRESS_WIDTH-1:0];
    assign unused_offset = ^head_addr[OFFSET_BITS-1:0];
    assign head_illegal  = !is_cache_op(head_op) && (head_op != OP_CLEAR) && (head_op != OP_PRINT);

    assign grant    = (state == S_ISSUE) && bus.req_ready;
    assign rsp_done = (state == S_WAIT_RSP) && bus.rsp_valid;
    assign inc_err  = (state == S_IDLE) && !fifo_empty && head_illegal;
    assign pop      = inc_err || grant || (state == S_CLEAR) || (state == S_PRINT);

    assign inc_read  = grant && ((req_kind_r == PR_READ) || (req_kind_r == PR_IFETCH));
    assign inc_write = grant && (req_kind_r == PR_WRITE);
    assign inc_hit   = rsp_done && is_proc_kind(req_kind_r) && bus.rsp_hit;
    assign inc_miss  = rsp_done && is_proc_kind(req_kind_r) && !bus.rsp_hit;

    assign bus.cmd_ready = !fifo_full;
    assign bus.req_valid = (state == S_ISSUE);
    assign bus.req_kind  = req_kind_r;
    assign bus.req_tag   = req_tag_r;
    assign bus.req_index = req_index_r;
    assign clear_pulse   = (state == S_CLEAR);
    assign print_pulse   = (state == S_PRINT);
    assign busy          = !fifo_empty || (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_kind_r  <= PR_READ;
            req_tag_r   <= '0;
            req_index_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_cache_op(head_op)) begin
                            state       <= S_ISSUE;
                            req_kind_r  <= op_to_kind(head_op);
                            req_tag_r   <= head_addr[ADDRESS_WIDTH-1 -: TAG_BITS];
                            req_index_r <= head_addr[OFFSET_BITS +: INDEX_BITS];
                        end else if (head_op == OP_CLEAR) begin
                            state <= S_CLEAR;
                        end else if (head_op == OP_PRINT) begin
                            state <= S_PRINT;
                        end
                    end
                end
                S_ISSUE:    if (bus.req_ready) state <= S_WAIT_RSP;
                S_WAIT_RSP: if (bus.rsp_valid) state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Clear has priority over any increment landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reads  <= '0;
            cnt_writes <= '0;
            cnt_hits   <= '0;
            cnt_misses <= '0;
            cnt_err    <= '0;
        end else if (state == S_CLEAR) begin
            cnt_reads  <= '0;
            cnt_writes <= '0;
            cnt_hits   <= '0;
            cnt_misses <= '0;
            cnt_err    <= '0;
        end else begin
            if (inc_read)  cnt_reads  <= sat_inc(cnt_reads);
            if (inc_write) cnt_writes <= sat_inc(cnt_writes);
            if (inc_hit)   cnt_hits   <= sat_inc(cnt_hits);
            if (inc_miss)  cnt_misses <= sat_inc(cnt_misses);
            if (inc_err)   cnt_err    <= sat_inc(cnt_err);
        end
    end

endmodule

// File: tb/tb_llc_cmd_dispatch.sv
// Self-checking bench for llc_cmd_dispatch: directed scenarios plus random
// commands, compared against a queue-based model of the dispatch rules.
module tb_llc_cmd_dispatch;
    import llc_cmd_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_pulse, print_pulse, busy;
    logic [31:0] cnt_reads, cnt_writes, cnt_hits, cnt_misses, cnt_err;

    llc_cmd_dispatch_if bus ();

    llc_cmd_dispatch #(.FIFO_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_pulse (clear_pulse),
        .print_pulse (print_pulse),
        .busy        (busy),
        .cnt_reads   (cnt_reads),
        .cnt_writes  (cnt_writes),
        .cnt_hits    (cnt_hits),
        .cnt_misses  (cnt_misses),
        .cnt_err     (cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
    } cmd_t;

    cmd_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_reads, m_writes, m_hits, m_misses, m_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bump(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic req_kind_t exp_kind(input logic [3:0] op);
        case (op)
            4'd0:    return PR_READ;
            4'd1:    return PR_WRITE;
            4'd2:    return PR_IFETCH;
            4'd3:    return SN_READ;
            4'd4:    return SN_WRITE;
            4'd5:    return SN_RWIM;
            default: return SN_INVAL;
        endcase
    endfunction

    task automatic model_zero();
        m_reads = 0; m_writes = 0; m_hits = 0; m_misses = 0; m_err = 0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".reads"},  cnt_reads,  m_reads);
        check({tag, ".writes"}, cnt_writes, m_writes);
        check({tag, ".hits"},   cnt_hits,   m_hits);
        check({tag, ".misses"}, cnt_misses, m_misses);
        check({tag, ".err"},    cnt_err,    m_err);
    endtask

    task automatic push_one(input logic [3:0] op, input logic [31:0] addr);
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        step();
        bus.cmd_valid = 1'b0;
        q.push_back('{op: op, addr: addr});
    endtask

    // Waits for the head request, checks its fields, holds off the grant
    // for 'delay' cycles, then grants it.
    task automatic grant_one(output cmd_t c, input int delay);
        int n = 0;
        while (bus.req_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("req_wait", 32'(bus.req_valid), 32'd1);
        c = q.pop_front();
        check("req_kind",  32'(bus.req_kind),  32'(exp_kind(c.op)));
        check("req_tag",   32'(bus.req_tag),   32'(c.addr >> 20));
        check("req_index", 32'(bus.req_index), (c.addr >> 6) & 32'h3FFF);
        for (int i = 0; i < delay; i++) begin
            step();
            check("hold_valid", 32'(bus.req_valid), 32'd1);
            check("hold_tag",   32'(bus.req_tag),   32'(c.addr >> 20));
            check("hold_index", 32'(bus.req_index), (c.addr >> 6) & 32'h3FFF);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        end
        bus.req_ready = 1'b1;
        step();
        bus.req_ready = 1'b0;
        if (c.op == 4'd0 || c.op == 4'd2) m_reads = bump(m_reads);
        if (c.op == 4'd1) m_writes = bump(m_writes);
        check("req_drop", 32'(bus.req_valid), 32'd0);
        check_cnts("grant");
    endtask

    task automatic respond_one(input cmd_t c, input logic hit);
        repeat ($urandom_range(0, 2)) step();
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = hit;
        step();
        bus.rsp_valid = 1'b0;
        bus.rsp_hit   = 1'b0;
        if (c.op <= 4'd2) begin
            if (hit) m_hits = bump(m_hits);
            else     m_misses = bump(m_misses);
        end
        check_cnts("rsp");
    endtask

    // One command into an idle, empty block, serviced to completion.
    task automatic run_cmd(input logic [3:0] op, input logic [31:0] addr,
                           input logic hit, input int delay);
        cmd_t c;
        push_one(op, addr);
        check("lat1_req_valid", 32'(bus.req_valid), 32'd0);
        check("lat1_busy", 32'(busy), 32'd1);
        step();
        if (op <= 4'd6) begin
            check("lat2_req_valid", 32'(bus.req_valid), 32'd1);
            grant_one(c, delay);
            respond_one(c, hit);
        end else if (op == 4'd8) begin
            check("clear_on", 32'(clear_pulse), 32'd1);
            check("clear_no_req", 32'(bus.req_valid), 32'd0);
            step();
            void'(q.pop_front());
            model_zero();
            check("clear_off", 32'(clear_pulse), 32'd0);
            check_cnts("clear");
        end else if (op == 4'd9) begin
            check("print_on", 32'(print_pulse), 32'd1);
            check("print_no_req", 32'(bus.req_valid), 32'd0);
            step();
            void'(q.pop_front());
            check("print_off", 32'(print_pulse), 32'd0);
            check_cnts("print");
        end else begin
            void'(q.pop_front());
            m_err = bump(m_err);
            check("illegal_no_req", 32'(bus.req_valid), 32'd0);
            check_cnts("illegal");
        end
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        cmd_t        c;
        cmd_t        burst[5];
        logic [3:0]  rop;

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_hit   = 1'b0;
        model_zero();
        step();
        step();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_clear", 32'(clear_pulse), 32'd0);
        check("rst_print", 32'(print_pulse), 32'd0);
        check_cnts("rst");
        rst = 1'b0;
        step();

        run_cmd(4'd0, 32'h1234_5678, 1'b0, 0);
        check("t1_reads", cnt_reads, 32'd1);
        check("t1_misses", cnt_misses, 32'd1);

        run_cmd(4'd1, 32'hFFFF_FFC0, 1'b1, 5);
        check("t2_writes", cnt_writes, 32'd1);
        check("t2_hits", cnt_hits, 32'd1);

        // Five back-to-back commands with the cache stalled.
        for (int i = 0; i < 5; i++) begin
            burst[i].op   = 4'($urandom_range(0, 6));
            burst[i].addr = $urandom;
        end
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("burst_ready", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_op   = burst[i].op;
            bus.cmd_addr = burst[i].addr;
            step();
            q.push_back(burst[i]);
        end
        bus.cmd_op   = burst[4].op;
        bus.cmd_addr = burst[4].addr;
        check("burst_full", 32'(bus.cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("burst_full_hold", 32'(bus.cmd_ready), 32'd0);
        end
        grant_one(c, 0);
        check("burst_no_bypass", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
        q.push_back(burst[4]);
        check("burst_refull", 32'(bus.cmd_ready), 32'd0);
        respond_one(c, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) begin
            grant_one(c, 0);
            respond_one(c, 1'($urandom_range(0, 1)));
        end
        check("burst_busy", 32'(busy), 32'd0);

        run_cmd(4'd4, 32'hA5A5_0040, 1'b1, 0);

        run_cmd(4'd7, 32'h0, 1'b0, 0);
        check("t5_err", cnt_err, 32'd1);
        run_cmd(4'd9, 32'h0, 1'b0, 0);
        run_cmd(4'd8, 32'h0, 1'b0, 0);
        check("t5_reads_zero", cnt_reads, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            run_cmd(rop, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset while a request is outstanding and three commands are queued.
        run_cmd(4'd2, $urandom, 1'b0, 0);
        push_one(4'd0, $urandom);
        grant_one(c, 0);
        for (int i = 0; i < 3; i++) push_one(4'($urandom_range(0, 6)), $urandom);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        model_zero();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req_valid", 32'(bus.req_valid), 32'd0);
        check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_cnts("arst");
        step();
        step();
        rst = 1'b0;
        step();
        bus.rsp_valid = 1'b1;
        bus.rsp_hit   = 1'b1;
        step();
        bus.rsp_valid = 1'b0;
        bus.rsp_hit   = 1'b0;
        step();
        check("late_rsp_busy", 32'(busy), 32'd0);
        check("late_rsp_req", 32'(bus.req_valid), 32'd0);
        check_cnts("late_rsp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
